// File: rtl/rx_pkg.sv
// Shared sizing defaults and width helpers for the UART receive block path.
// Latency: n/a (package).
// Backpressure: n/a (package).
package rx_pkg;

    localparam int BYTE_W_DEF      = 8;
    localparam int BLOCK_BYTES_DEF = 16;

    // Assembled block width in bits.
    function automatic int block_w(input int byte_w, input int block_bytes);
        return byte_w * block_bytes;
    endfunction

    // FIFO address width; pointers carry one extra wrap bit on top of this.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Idle counter width, wide enough to hold timeout-1.
    function automatic int idle_w(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/rx_block_packer.sv
// Packs receiver bytes MSB-first into one block; blk_valid is combinational on the last byte.
// Latency: blk/blk_valid are valid in the same cycle as the final din_valid strobe.
// Backpressure: none; the packer never stalls, the consumer must take or drop blk.
//
// Ports: clk, reset (async active-low), din/din_valid (byte strobe in),
//        blk/blk_valid (completed block out), byte_cnt (partial fill), to_flag (discard strobe).
// Optional: RX_TIMEOUT_EN adds an idle counter that discards stale partial blocks.
module rx_block_packer
    import rx_pkg::*;
#(
    parameter int BYTE_W      = BYTE_W_DEF,
    parameter int BLOCK_BYTES = BLOCK_BYTES_DEF,
    parameter int TIMEOUT     = 1024
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [BYTE_W-1:0]                  din,
    input  logic                               din_valid,
    output logic [block_w(BYTE_W, BLOCK_BYTES)-1:0] blk,
    output logic                               blk_valid,
    output logic [$clog2(BLOCK_BYTES)-1:0]     byte_cnt,
    output logic                               to_flag
);

    localparam int BLOCK_W = block_w(BYTE_W, BLOCK_BYTES);
    localparam int SHIFT_W = BLOCK_W - BYTE_W;
    localparam int CNT_W   = $clog2(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BYTES - 1);

    logic [SHIFT_W-1:0] shift_reg;
    logic [CNT_W-1:0]   cnt;
    logic               discard;

    // Final byte bypasses the shift register so the block leaves on the same edge.
    assign blk_valid = din_valid && (cnt == LAST_IDX);
    assign blk       = {shift_reg, din};
    assign byte_cnt  = cnt;

`ifdef RX_TIMEOUT_EN
    localparam int IDLE_W = idle_w(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_cnt;

    // A byte arriving in the timeout cycle takes priority over the discard.
    assign discard = !din_valid && (cnt != '0) && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
            to_flag  <= 1'b0;
        end else begin
            to_flag <= discard;
            if (din_valid || (cnt == '0) || discard) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    assign discard = 1'b0;
    assign to_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            cnt       <= '0;
        end else if (din_valid) begin
            if (cnt == LAST_IDX) begin
                cnt       <= '0;
                shift_reg <= '0;
            end else begin
                cnt       <= cnt + 1'b1;
                // Truncating cast keeps the newest SHIFT_W bits.
                shift_reg <= SHIFT_W'({shift_reg, din});
            end
        end else if (discard) begin
            cnt       <= '0;
            shift_reg <= '0;
        end
    end

endmodule

// File: rtl/rx_block_fifo.sv
// Assembles UART bytes into blocks and queues them FWFT in a DEPTH-entry FIFO for the AES core.
// Latency: block visible on dout (empty=0) the cycle after the edge sampling its last byte.
// Backpressure: none upstream; a block completing while full is dropped and sets sticky of.
//
// Ports: clk, reset (async active-low), din/din_valid (UART byte strobe), re (pop, ignored when
//        empty), of_clr (clear overflow), dout (head block, 0 when empty), empty, full, of, count,
//        byte_cnt (partial block fill), to_flag (partial block discarded).
// Optional: RX_TIMEOUT_EN enables partial-block discard after TIMEOUT idle cycles.
module rx_block_fifo
    import rx_pkg::*;
#(
    parameter int BYTE_W      = BYTE_W_DEF,
    parameter int BLOCK_BYTES = BLOCK_BYTES_DEF,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [BYTE_W-1:0]                       din,
    input  logic                                    din_valid,
    input  logic                                    re,
    input  logic                                    of_clr,
    output logic [block_w(BYTE_W, BLOCK_BYTES)-1:0] dout,
    output logic                                    empty,
    output logic                                    full,
    output logic                                    of,
    output logic [$clog2(DEPTH+1)-1:0]              count,
    output logic [$clog2(BLOCK_BYTES)-1:0]          byte_cnt,
    output logic                                    to_flag
);

    localparam int BLOCK_W = block_w(BYTE_W, BLOCK_BYTES);
    localparam int PW      = ptr_w(DEPTH);
    localparam int CW      = $clog2(DEPTH + 1);

    logic [BLOCK_W-1:0] blk;
    logic               blk_valid;
    logic [BLOCK_W-1:0] mem [DEPTH];
    logic [PW:0]        wr_ptr;
    logic [PW:0]        rd_ptr;
    logic               pop;
    logic               push;
    logic               drop;

    rx_block_packer #(
        .BYTE_W      (BYTE_W),
        .BLOCK_BYTES (BLOCK_BYTES),
        .TIMEOUT     (TIMEOUT)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .blk       (blk),
        .blk_valid (blk_valid),
        .byte_cnt  (byte_cnt),
        .to_flag   (to_flag)
    );

    // Same-address compare with differing wrap bits means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign count = CW'(wr_ptr - rd_ptr);

    // A pop in the same cycle frees the slot a full-FIFO write needs.
    assign pop  = re && !empty;
    assign push = blk_valid && (!full || pop);
    assign drop = blk_valid && full && !pop;

    assign dout = empty ? '0 : mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= blk;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            of     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Set has priority over clear.
            if (drop) begin
                of <= 1'b1;
            end else if (of_clr) begin
                of <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_block_fifo.sv
// Directed bench for rx_block_fifo with hand-computed block values.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_block_fifo;

    logic         clk;
    logic         reset;
    logic [7:0]   din;
    logic         din_valid;
    logic         re;
    logic         of_clr;
    logic [127:0] dout;
    logic         empty;
    logic         full;
    logic         of;
    logic [2:0]   count;
    logic [3:0]   byte_cnt;
    logic         to_flag;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] B1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] B2 = 128'hFFEEDDCCBBAA99887766554433221100;
    localparam logic [127:0] B3 = {16{8'hA5}};
    localparam logic [127:0] B4 = {16{8'h5A}};
    localparam logic [127:0] B5 = {16{8'hC3}};
    localparam logic [127:0] B6 = {16{8'h3C}};

    rx_block_fifo #(
        .BYTE_W      (8),
        .BLOCK_BYTES (16),
        .DEPTH       (4),
        .TIMEOUT     (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .re        (re),
        .of_clr    (of_clr),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .of        (of),
        .count     (count),
        .byte_cnt  (byte_cnt),
        .to_flag   (to_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        din       = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    // Sends a block MSB byte first; optionally raises re and/or of_clr alongside the last byte.
    task automatic send_block(input logic [127:0] blk, input bit pop_last, input bit clr_last);
        for (int i = 0; i < 16; i++) begin
            din       = blk[127 - 8*i -: 8];
            din_valid = 1'b1;
            re        = pop_last && (i == 15);
            of_clr    = clr_last && (i == 15);
            tick();
        end
        din_valid = 1'b0;
        re        = 1'b0;
        of_clr    = 1'b0;
    endtask

    task automatic pop();
        re = 1'b1;
        tick();
        re = 1'b0;
    endtask

    task automatic pulse_of_clr();
        of_clr = 1'b1;
        tick();
        of_clr = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        re        = 1'b0;
        of_clr    = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_dout", dout, '0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_of", of, 0);
        check("rst_count", count, 0);
        check("rst_byte_cnt", byte_cnt, 0);
        check("rst_to_flag", to_flag, 0);
        reset = 1'b1;

        // Asynchronous reset mid-stream: one queued block plus a partial one
        send_block(B1, 0, 0);
        for (int i = 0; i < 3; i++) send_byte(8'h42);
        check("pre_arst_count", count, 1);
        check("pre_arst_byte_cnt", byte_cnt, 3);
        #2;
        reset = 1'b0;
        #1;
        check("arst_empty", empty, 1);
        check("arst_dout", dout, '0);
        check("arst_count", count, 0);
        check("arst_byte_cnt", byte_cnt, 0);
        repeat (2) tick();
        check("arst_hold_empty", empty, 1);
        reset = 1'b1;
        tick();

        // Byte order and single-block latency
        for (int i = 0; i < 15; i++) send_byte(B1[127 - 8*i -: 8]);
        check("b1_not_yet_empty", empty, 1);
        send_byte(B1[7:0]);
        check("b1_empty", empty, 0);
        check("b1_count", count, 1);
        check("b1_dout", dout, B1);
        check("b1_byte_cnt", byte_cnt, 0);

        // Fill to full, then overflow
        send_block(B2, 0, 0);
        send_block(B3, 0, 0);
        check("fill3_full", full, 0);
        check("fill3_count", count, 3);
        send_block(B4, 0, 0);
        check("fill4_full", full, 1);
        check("fill4_count", count, 4);
        check("fill4_of", of, 0);
        send_block(B5, 0, 0);
        check("ovf_of", of, 1);
        check("ovf_count", count, 4);
        check("ovf_dout", dout, B1);
        pulse_of_clr();
        check("of_clr", of, 0);

        // Full with a pop on the last byte: write succeeds
        send_block(B6, 1, 0);
        check("simul_of", of, 0);
        check("simul_count", count, 4);
        check("simul_full", full, 1);
        check("simul_dout", dout, B2);

        // Drain in order; B6 must be at the tail
        pop();
        check("drain1_dout", dout, B3);
        pop();
        check("drain2_dout", dout, B4);
        pop();
        check("drain3_dout", dout, B6);
        check("drain3_count", count, 1);
        pop();
        check("drain4_empty", empty, 1);
        check("drain4_dout", dout, '0);
        pop();
        check("drain5_count", count, 0);
        check("drain5_empty", empty, 1);
        check("drain5_full", full, 0);

        // Write and pop together at occupancy 1
        send_block(B1, 0, 0);
        send_block(B2, 1, 0);
        check("wrpop_count", count, 1);
        check("wrpop_dout", dout, B2);
        pop();
        check("wrpop_empty", empty, 1);

        // of_clr concurrent with an overflow: set wins
        send_block(B3, 0, 0);
        send_block(B4, 0, 0);
        send_block(B5, 0, 0);
        send_block(B6, 0, 0);
        send_block(B1, 0, 1);
        check("clr_vs_set_of", of, 1);
        check("clr_vs_set_dout", dout, B3);
        pulse_of_clr();
        check("clr_after_of", of, 0);
        for (int i = 0; i < 4; i++) pop();
        check("clr_drain_empty", empty, 1);

        // Partial block followed by a long idle gap
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        check("idle_start_byte_cnt", byte_cnt, 5);
        repeat (63) tick();
        check("idle63_to_flag", to_flag, 0);
        check("idle63_byte_cnt", byte_cnt, 5);
        tick();
`ifdef RX_TIMEOUT_EN
        check("to_flag_pulse", to_flag, 1);
        check("to_byte_cnt", byte_cnt, 0);
        tick();
        check("to_flag_drop", to_flag, 0);
        send_block(B3, 0, 0);
        check("to_clean_dout", dout, B3);
        check("to_clean_count", count, 1);
`else
        check("no_to_flag", to_flag, 0);
        check("no_to_byte_cnt", byte_cnt, 5);
        for (int i = 0; i < 11; i++) send_byte(8'h77);
        check("no_to_dout", dout, {40'h0102030405, {11{8'h77}}});
        check("no_to_count", count, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
